instr_fetch: RTL and testbench

- Front-end stage directly upstream of the 8-bit CPU datapath.
- Holds a loadable program memory of 13-bit instructions and sequences a program counter.
- Presents one instruction per cycle to the CPU over a valid/ready handshake.
- Supports jumps, wrap-around, and a HALT sentinel that stops issue until restarted.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/instr_mem.sv | 17 +
 rtl/instr_fetch.sv | 53 +++++
 tb/tb_instr_fetch.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, halt sentinel and state encoding for the fetch stage
package fetch_pkg;
  localparam int INSTR_W = 13;
  localparam int ADDR_W = 5;
  localparam logic [INSTR_W-1:0] HALT_WORD = 13'h1FFF;
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: program memory with synchronous write and asynchronous read
module instr_mem #(
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DEPTH = 2**ADDR_W
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequences the pc through program memory and presents one instruction per cycle
module instr_fetch #(
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DEPTH = 2**ADDR_W,
  parameter logic [INSTR_W-1:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);
  import fetch_pkg::*;
  state_t state, state_n;
  logic [ADDR_W-1:0] rd_addr;
  logic [INSTR_W-1:0] mem_data, word;
  logic wr_en, take, halt_hit;
  assign wr_en = load_en && state != FETCH;
  assign rd_addr = state != FETCH ? '0 : jump_en ? jump_addr : pc + 1'b1;
  instr_mem #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(wr_en), .waddr(load_addr), .wdata(load_data),
    .raddr(rd_addr), .rdata(mem_data)
  );
  // a write landing in the same cycle as start is forwarded to the read
  assign word = wr_en && load_addr == rd_addr ? load_data : mem_data;
  assign halt_hit = word == HALT_WORD;
  assign take = state == FETCH ? jump_en || instr_ready : start;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb state_n = take ? (halt_hit ? HALT : FETCH) : state;
  always_comb begin
    instr_valid = state == FETCH;
    halted = state == HALT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= '0;
      instr <= '0;
    end else if (take) begin
      pc <= rd_addr;
      if (!halt_hit) instr <= word;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed table plus hand sequences for instr_fetch
module tb_instr_fetch;
  logic clk = 0, reset = 1, start = 0, load_en = 0, jump_en = 0, instr_ready = 0;
  logic [4:0] load_addr = 0, jump_addr = 0, pc;
  logic [12:0] load_data = 0, instr;
  logic instr_valid, halted;
  int errors = 0, checks = 0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .jump_en(jump_en), .jump_addr(jump_addr), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, ld; logic [4:0] la; logic [12:0] ldat;
    logic jp; logic [4:0] ja; logic rdy;
    logic ev; logic [12:0] ei; logic [4:0] ep; logic eh;
  } vec_t;

  function automatic vec_t v(int st, int ld, int la, int ldat, int jp, int ja, int rdy,
                             int ev, int ei, int ep, int eh);
    vec_t r;
    r.st = st[0]; r.ld = ld[0]; r.la = la[4:0]; r.ldat = ldat[12:0];
    r.jp = jp[0]; r.ja = ja[4:0]; r.rdy = rdy[0];
    r.ev = ev[0]; r.ei = ei[12:0]; r.ep = ep[4:0]; r.eh = eh[0];
    return r;
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic outs(string n, int ev, int ei, int ep, int eh);
    chk({n, ".valid"}, int'(instr_valid), ev);
    chk({n, ".instr"}, int'(instr), ei);
    chk({n, ".pc"}, int'(pc), ep);
    chk({n, ".halted"}, int'(halted), eh);
  endtask

  // drive at the negedge, sample 1 time unit after the next posedge, return to the negedge
  task automatic cyc(int st, int ld, int la, int ldat, int jp, int ja, int rdy);
    start = st[0]; load_en = ld[0]; load_addr = la[4:0]; load_data = ldat[12:0];
    jump_en = jp[0]; jump_addr = ja[4:0]; instr_ready = rdy[0];
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [23];

  initial begin
    tbl[0]  = v(0,1,0,'h0A05,0,0,0, 0,'h0000,0,0);
    tbl[1]  = v(0,1,1,'h1203,0,0,0, 0,'h0000,0,0);
    tbl[2]  = v(0,1,2,'h1FFF,0,0,0, 0,'h0000,0,0);
    tbl[3]  = v(1,0,0,0,      0,0,1, 1,'h0A05,0,0);
    tbl[4]  = v(0,0,0,0,      0,0,1, 1,'h1203,1,0);
    tbl[5]  = v(0,0,0,0,      0,0,1, 0,'h1203,2,1);
    tbl[6]  = v(0,0,0,0,      1,0,1, 0,'h1203,2,1);
    tbl[7]  = v(1,0,0,0,      0,0,0, 1,'h0A05,0,0);
    tbl[8]  = v(0,0,0,0,      0,0,0, 1,'h0A05,0,0);
    tbl[9]  = v(0,0,0,0,      0,0,0, 1,'h0A05,0,0);
    tbl[10] = v(0,0,0,0,      0,0,1, 1,'h1203,1,0);
    tbl[11] = v(1,0,0,0,      0,0,0, 1,'h1203,1,0);
    tbl[12] = v(0,1,1,'h0777, 0,0,0, 1,'h1203,1,0);
    tbl[13] = v(0,0,0,0,      1,1,0, 1,'h1203,1,0);
    tbl[14] = v(0,0,0,0,      1,0,1, 1,'h0A05,0,0);
    tbl[15] = v(0,0,0,0,      0,0,1, 1,'h1203,1,0);
    tbl[16] = v(0,0,0,0,      0,0,1, 0,'h1203,2,1);
    tbl[17] = v(0,1,1,'h0777, 0,0,0, 0,'h1203,2,1);
    tbl[18] = v(1,1,0,'h0333, 0,0,1, 1,'h0333,0,0);
    tbl[19] = v(0,0,0,0,      0,0,1, 1,'h0777,1,0);
    tbl[20] = v(0,0,0,0,      0,0,1, 0,'h0777,2,1);
    tbl[21] = v(0,1,0,'h1FFF, 0,0,0, 0,'h0777,2,1);
    tbl[22] = v(1,0,0,0,      0,0,0, 0,'h0777,0,1);

    #3;
    outs("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].st, tbl[i].ld, tbl[i].la, tbl[i].ldat, tbl[i].jp, tbl[i].ja, tbl[i].rdy);
      outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].eh);
      @(negedge clk);
    end

    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, i, i, 0, 0, 0);
      @(negedge clk);
    end
    cyc(1, 0, 0, 0, 0, 0, 1);
    outs("run0", 1, 0, 0, 0);
    @(negedge clk);
    for (int k = 1; k <= 35; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      outs($sformatf("run%0d", k), 1, k % 32, k % 32, 0);
      @(negedge clk);
    end
    cyc(0, 0, 0, 0, 1, 20, 1);
    outs("jump20", 1, 20, 20, 0);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1);
    outs("after_jump", 1, 21, 21, 0);
    @(negedge clk);

    instr_ready = 0;
    #1 reset = 1;
    #1 outs("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 0;
    cyc(1, 0, 0, 0, 0, 0, 1);
    outs("restart0", 1, 0, 0, 0);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1);
    outs("restart1", 1, 1, 1, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
